// File: rtl/rsa_exp_arbiter.sv
// rtl/rsa_exp_arbiter.sv - round-robin arbiter/sequencer sharing one montgomery_exp core
//
// Purpose: accepts one job per valid/ready handshake from requester r0 or r1,
// loads the core operand registers, pulses core_start, waits for core_done
// (or the optional watchdog), then presents result + requester id on a
// valid/ready response port.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   rK_valid / rK_ready         job handshake per requester (K = 0, 1)
//   rK_encryp_mode, rK_msg, rK_exp, rK_n, rK_rmodn, rK_r2modn   job operands
//   core_start                  one-cycle start pulse to the core
//   core_encryp_mode, core_msg, core_exp, core_n, core_rmodn, core_r2modn
//                               registered operands, held after the job
//   core_result, core_done      core completion inputs (sampled in WAIT only)
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_error, rsp_result  response payload
//   busy, state_dbg             status / debug
module rsa_exp_arbiter #(
  parameter int WIDTH          = 1024,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic             r0_encryp_mode,
  input  logic [WIDTH-1:0] r0_msg,
  input  logic [WIDTH-1:0] r0_exp,
  input  logic [WIDTH-1:0] r0_n,
  input  logic [WIDTH-1:0] r0_rmodn,
  input  logic [WIDTH-1:0] r0_r2modn,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic             r1_encryp_mode,
  input  logic [WIDTH-1:0] r1_msg,
  input  logic [WIDTH-1:0] r1_exp,
  input  logic [WIDTH-1:0] r1_n,
  input  logic [WIDTH-1:0] r1_rmodn,
  input  logic [WIDTH-1:0] r1_r2modn,
  output logic             core_start,
  output logic             core_encryp_mode,
  output logic [WIDTH-1:0] core_msg,
  output logic [WIDTH-1:0] core_exp,
  output logic [WIDTH-1:0] core_n,
  output logic [WIDTH-1:0] core_rmodn,
  output logic [WIDTH-1:0] core_r2modn,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_error,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic [31:0] wdog;
  logic        grant_valid;
  logic        grant_id;
  logic        timeout_hit;

  // On a tie the requester that was not served last wins; last_grant resets
  // to 1 so r0 wins the first tie after reset.
  always_comb begin
    grant_valid = r0_valid | r1_valid;
    if (r0_valid && r1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = r1_valid;
    end
  end

  assign r0_ready    = (state == IDLE) && grant_valid && !grant_id;
  assign r1_ready    = (state == IDLE) && grant_valid && grant_id;
  assign core_start  = (state == START);
  assign busy        = (state != IDLE);
  assign state_dbg   = state;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (core_done || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      wdog             <= '0;
      core_encryp_mode <= 1'b0;
      core_msg         <= '0;
      core_exp         <= '0;
      core_n           <= '0;
      core_rmodn       <= '0;
      core_r2modn      <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= 1'b0;
      rsp_error        <= 1'b0;
      rsp_result       <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            core_encryp_mode <= grant_id ? r1_encryp_mode : r0_encryp_mode;
            core_msg         <= grant_id ? r1_msg    : r0_msg;
            core_exp         <= grant_id ? r1_exp    : r0_exp;
            core_n           <= grant_id ? r1_n      : r0_n;
            core_rmodn       <= grant_id ? r1_rmodn  : r0_rmodn;
            core_r2modn      <= grant_id ? r1_r2modn : r0_r2modn;
            rsp_id           <= grant_id;
            last_grant       <= grant_id;
          end
        end
        START: wdog <= '0;
        WAIT: begin
          wdog <= wdog + 32'd1;
          // A completion in the same cycle as the timeout still counts as success.
          if (core_done) begin
            rsp_result <= core_result;
            rsp_error  <= 1'b0;
            rsp_valid  <= 1'b1;
          end else if (timeout_hit) begin
            rsp_result <= '0;
            rsp_error  <= 1'b1;
            rsp_valid  <= 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_exp_arbiter.sv
// tb/tb_rsa_exp_arbiter.sv - directed self-checking bench for rsa_exp_arbiter
module tb_rsa_exp_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic         r0_valid, r1_valid, r0_ready, r1_ready;
  logic         r0_encryp_mode, r1_encryp_mode;
  logic [W-1:0] r0_msg, r0_exp, r0_n, r0_rmodn, r0_r2modn;
  logic [W-1:0] r1_msg, r1_exp, r1_n, r1_rmodn, r1_r2modn;
  logic         core_start, core_encryp_mode, core_done;
  logic [W-1:0] core_msg, core_exp, core_n, core_rmodn, core_r2modn, core_result;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_error, busy;
  logic [W-1:0] rsp_result;
  logic [2:0]   state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rsa_exp_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_encryp_mode(r0_encryp_mode),
    .r0_msg(r0_msg), .r0_exp(r0_exp), .r0_n(r0_n), .r0_rmodn(r0_rmodn), .r0_r2modn(r0_r2modn),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_encryp_mode(r1_encryp_mode),
    .r1_msg(r1_msg), .r1_exp(r1_exp), .r1_n(r1_n), .r1_rmodn(r1_rmodn), .r1_r2modn(r1_r2modn),
    .core_start(core_start), .core_encryp_mode(core_encryp_mode),
    .core_msg(core_msg), .core_exp(core_exp), .core_n(core_n),
    .core_rmodn(core_rmodn), .core_r2modn(core_r2modn),
    .core_result(core_result), .core_done(core_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_error(rsp_error), .rsp_result(rsp_result),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Core stub: result = msg^exp mod n, done pulsed done_delay cycles after
  // the start cycle (done_delay = 0 means never).
  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    logic [31:0] r, x;
    if (m == 0) return '0;
    r = 32'd1 % {16'd0, m};
    x = {16'd0, b} % {16'd0, m};
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % {16'd0, m};
      x = (x * x) % {16'd0, m};
    end
    return r[W-1:0];
  endfunction

  assign core_result = modexp(core_msg, core_exp, core_n);

  int   done_delay = 5;
  int   stub_cnt   = 0;
  logic stub_done  = 1'b0;
  logic stray_done = 1'b0;
  assign core_done = stub_done | stray_done;

  always @(negedge clk) begin
    stub_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) stub_done = 1'b1;
    end
    if (core_start === 1'b1 && done_delay > 0) stub_cnt = done_delay;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the START cycle S; returns in the first RESP cycle S+d+1.
  task automatic finish_job(input string tag, input int d, input logic eid,
                            input logic [W-1:0] eres, input logic eerr);
    check({tag, "_start"}, {31'd0, core_start}, 32'd1);
    check({tag, "_st_start"}, {29'd0, state_dbg}, 32'd1);
    tick;
    check({tag, "_start_low"}, {31'd0, core_start}, 32'd0);
    check({tag, "_st_wait"}, {29'd0, state_dbg}, 32'd2);
    repeat (d - 1) tick;
    check({tag, "_vld_early"}, {31'd0, rsp_valid}, 32'd0);
    tick;
    check({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_st_resp"}, {29'd0, state_dbg}, 32'd3);
    check({tag, "_id"}, {31'd0, rsp_id}, {31'd0, eid});
    check({tag, "_res"}, {16'd0, rsp_result}, {16'd0, eres});
    check({tag, "_err"}, {31'd0, rsp_error}, {31'd0, eerr});
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    #1;
    check({tag, "_rel_r0rdy"}, {31'd0, r0_ready}, 32'd0);
    check({tag, "_rel_r1rdy"}, {31'd0, r1_ready}, 32'd0);
    tick;
    rsp_ready = 1'b0;
    check({tag, "_rel_vld"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rel_idle"}, {29'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; rsp_ready = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_encryp_mode = 1'b1; r1_encryp_mode = 1'b0;
    r0_msg = 16'd3; r0_exp = 16'd5; r0_n = 16'd33; r0_rmodn = 16'h00a1; r0_r2modn = 16'h00b2;
    r1_msg = 16'd2; r1_exp = 16'd10; r1_n = 16'd1000; r1_rmodn = 16'h01c3; r1_r2modn = 16'h01d4;

    // Reset state
    repeat (3) tick;
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_vld", {31'd0, rsp_valid}, 32'd0);
    check("rst_start", {31'd0, core_start}, 32'd0);
    check("rst_msg", {16'd0, core_msg}, 32'd0);
    check("rst_err", {31'd0, rsp_error}, 32'd0);
    resetn = 1'b1;
    tick;

    // 1: r0 alone, 3^5 mod 33 = 12
    r0_valid = 1'b1;
    #1;
    check("t1_r0rdy", {31'd0, r0_ready}, 32'd1);
    check("t1_r1rdy", {31'd0, r1_ready}, 32'd0);
    tick;
    r0_valid = 1'b0;
    check("t1_r0rdy_gone", {31'd0, r0_ready}, 32'd0);
    check("t1_msg", {16'd0, core_msg}, 32'd3);
    check("t1_n", {16'd0, core_n}, 32'd33);
    check("t1_r2", {16'd0, core_r2modn}, 32'h00b2);
    check("t1_mode", {31'd0, core_encryp_mode}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    finish_job("t1", 5, 1'b0, 16'd12, 1'b0);
    release_rsp("t1");
    check("t1_hold_msg", {16'd0, core_msg}, 32'd3);

    // 2: tie from reset -> r0, then r1, then tie -> r0 again
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    r0_msg = 16'd7; r0_exp = 16'd3; r0_n = 16'd50;
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    check("t2_tie_r0rdy", {31'd0, r0_ready}, 32'd1);
    check("t2_tie_r1rdy", {31'd0, r1_ready}, 32'd0);
    tick;
    r0_valid = 1'b0;
    check("t2_r1rdy_busy", {31'd0, r1_ready}, 32'd0);
    finish_job("t2a", 5, 1'b0, 16'd43, 1'b0);
    release_rsp("t2a");
    check("t2_r1rdy", {31'd0, r1_ready}, 32'd1);
    tick;
    r1_valid = 1'b0;
    check("t2_r1_mode", {31'd0, core_encryp_mode}, 32'd0);
    check("t2_r1_rmodn", {16'd0, core_rmodn}, 32'h01c3);
    finish_job("t2b", 5, 1'b1, 16'd24, 1'b0);
    release_rsp("t2b");
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    check("t2_tie2_r0rdy", {31'd0, r0_ready}, 32'd1);
    check("t2_tie2_r1rdy", {31'd0, r1_ready}, 32'd0);
    tick;
    r0_valid = 1'b0; r1_valid = 1'b0;
    finish_job("t2c", 5, 1'b0, 16'd43, 1'b0);
    release_rsp("t2c");

    // 3: response back-pressure, 5^3 mod 13 = 8
    r0_msg = 16'd5; r0_exp = 16'd3; r0_n = 16'd13;
    r0_valid = 1'b1;
    tick;
    r0_valid = 1'b0;
    finish_job("t3", 5, 1'b0, 16'd8, 1'b0);
    r1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("t3_hold_vld", {31'd0, rsp_valid}, 32'd1);
      check("t3_hold_res", {16'd0, rsp_result}, 32'd8);
      check("t3_hold_r1rdy", {31'd0, r1_ready}, 32'd0);
    end
    release_rsp("t3");
    check("t3_r1rdy_after", {31'd0, r1_ready}, 32'd1);
    tick;
    r1_valid = 1'b0;
    finish_job("t3b", 5, 1'b1, 16'd24, 1'b0);
    release_rsp("t3b");

    // 4: core never finishes -> watchdog abort, rsp_valid 9 cycles after start
    done_delay = 0;
    r0_valid = 1'b1;
    tick;
    r0_valid = 1'b0;
    finish_job("t4", 8, 1'b0, 16'd0, 1'b1);
    release_rsp("t4");

    // 5: done lands on the timeout cycle -> success; then a stray done in IDLE
    done_delay = 8;
    r0_msg = 16'd3; r0_exp = 16'd5; r0_n = 16'd33;
    r0_valid = 1'b1;
    tick;
    r0_valid = 1'b0;
    finish_job("t5", 8, 1'b0, 16'd12, 1'b0);
    release_rsp("t5");
    done_delay = 5;
    stray_done = 1'b1;
    tick;
    stray_done = 1'b0;
    check("t5_stray_state", {29'd0, state_dbg}, 32'd0);
    check("t5_stray_vld", {31'd0, rsp_valid}, 32'd0);
    tick;
    check("t5_stray_state2", {29'd0, state_dbg}, 32'd0);

    // 6: reset while waiting on the core; afterwards r0 wins the tie
    r1_valid = 1'b1;
    tick;
    r1_valid = 1'b0;
    tick;
    tick;
    check("t6_in_wait", {29'd0, state_dbg}, 32'd2);
    resetn = 1'b0;
    tick;
    check("t6_state", {29'd0, state_dbg}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_vld", {31'd0, rsp_valid}, 32'd0);
    check("t6_start", {31'd0, core_start}, 32'd0);
    check("t6_msg", {16'd0, core_msg}, 32'd0);
    resetn = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    check("t6_tie_r0rdy", {31'd0, r0_ready}, 32'd1);
    check("t6_tie_r1rdy", {31'd0, r1_ready}, 32'd0);
    tick;
    r0_valid = 1'b0; r1_valid = 1'b0;
    check("t6_accept_id", {31'd0, core_msg == 16'd3}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
